// File: rtl/riscv_alu_pkg.sv
// Shared opcodes, FSM state type and opcode-class helpers for the multi-cycle
// integer execute unit.
package riscv_alu_pkg;

  localparam int OPW = 5;

  localparam logic [OPW-1:0] OP_ADD    = 5'd1;
  localparam logic [OPW-1:0] OP_SUB    = 5'd2;
  localparam logic [OPW-1:0] OP_AND    = 5'd3;
  localparam logic [OPW-1:0] OP_OR     = 5'd4;
  localparam logic [OPW-1:0] OP_XOR    = 5'd5;
  localparam logic [OPW-1:0] OP_SLL    = 5'd6;
  localparam logic [OPW-1:0] OP_SRL    = 5'd7;
  localparam logic [OPW-1:0] OP_SRA    = 5'd8;
  localparam logic [OPW-1:0] OP_SLT    = 5'd9;
  localparam logic [OPW-1:0] OP_LUI    = 5'd10;
  localparam logic [OPW-1:0] OP_SLTU   = 5'd11;
  localparam logic [OPW-1:0] OP_BGE    = 5'd12;
  localparam logic [OPW-1:0] OP_BGEU   = 5'd13;
  localparam logic [OPW-1:0] OP_ADDPC  = 5'd14;
  localparam logic [OPW-1:0] OP_JBADDR = 5'd15;
  localparam logic [OPW-1:0] OP_BNE    = 5'd16;
  localparam logic [OPW-1:0] OP_BLT    = 5'd17;
  localparam logic [OPW-1:0] OP_BLTU   = 5'd18;
  localparam logic [OPW-1:0] OP_MUL    = 5'd19;
  localparam logic [OPW-1:0] OP_MULH   = 5'd20;
  localparam logic [OPW-1:0] OP_MULHSU = 5'd21;
  localparam logic [OPW-1:0] OP_MULHU  = 5'd22;
  localparam logic [OPW-1:0] OP_DIV    = 5'd23;
  localparam logic [OPW-1:0] OP_DIVU   = 5'd24;
  localparam logic [OPW-1:0] OP_REM    = 5'd25;
  localparam logic [OPW-1:0] OP_REMU   = 5'd26;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} alu_state_t;

  function automatic logic is_mop(input logic [OPW-1:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  function automatic logic is_mul_op(input logic [OPW-1:0] op);
    return (op >= OP_MUL) && (op <= OP_MULHU);
  endfunction

  function automatic logic is_rem_op(input logic [OPW-1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/riscv_alu_divider.sv
// Restoring divider: one quotient bit per cycle for XLEN cycles on magnitudes,
// with sign and divide-by-zero fixups applied to the final step.
module riscv_alu_divider
  import riscv_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN);

  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic            neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, dz_q, dz_d;

  logic [XLEN:0]   rem_shift, diff;
  logic            ge;
  logic [XLEN-1:0] rem_next, quo_next;
  logic            sa, sb;

  assign sa        = is_signed & dividend[XLEN-1];
  assign sb        = is_signed & divisor[XLEN-1];
  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign diff      = rem_shift - {1'b0, dvs_q};
  assign ge        = ~diff[XLEN];
  assign rem_next  = ge ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
  assign quo_next  = {quo_q[XLEN-2:0], ge};

  // A zero divisor never fails the trial subtract, so the raw quotient is all
  // ones and the remainder is |dividend|; only a signed quotient needs override.
  assign done      = busy_q && (cnt_q == CW'(XLEN - 1));
  assign quotient  = dz_q ? '1 : (neg_quo_q ? -quo_next : quo_next);
  assign remainder = neg_rem_q ? -rem_next : rem_next;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    if (start) begin
      busy_d    = 1'b1;
      cnt_d     = '0;
      rem_d     = '0;
      quo_d     = sa ? -dividend : dividend;
      dvs_d     = sb ? -divisor : divisor;
      neg_quo_d = sa ^ sb;
      neg_rem_d = sa;
      dz_d      = (divisor == '0);
    end else if (busy_q) begin
      rem_d = rem_next;
      quo_d = quo_next;
      cnt_d = cnt_q + CW'(1);
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n || flush) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // NOTE: datapath registers are reloaded on start and only read while busy, so they carry no reset.
  always_ff @(posedge clk) begin
    rem_q     <= rem_d;
    quo_q     <= quo_d;
    dvs_q     <= dvs_d;
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
    dz_q      <= dz_d;
  end

endmodule

// File: rtl/riscv_alu_mc.sv
// Multi-cycle integer execute unit: single-pass base ALU ops plus iterative
// RV32M multiply (shift-add) and divide, with valid/ready on both sides.
module riscv_alu_mc #(
  parameter int XLEN       = 32,
  parameter int MUL_UNROLL = 1,
  parameter int OPW        = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);
  import riscv_alu_pkg::*;

  localparam int SHW     = $clog2(XLEN);
  localparam int CW      = $clog2(XLEN) + 1;
  localparam int MUL_CYC = XLEN / MUL_UNROLL;

  alu_state_t        state_q, state_d;
  logic [OPW-1:0]    op_q, op_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic [2*XLEN-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_step, prod;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]     mcnt_q, mcnt_d;
  logic              mneg_q, mneg_d;

  logic              accept, lt_s, lt_u, eq, mul_sa, mul_sb;
  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   base_res, a_mag, b_mag;
  logic              div_start, div_done;
  logic [XLEN-1:0]   div_quo, div_rem;

  assign accept    = in_valid && in_ready;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;

  assign lt_s  = $signed(src_a) < $signed(src_b);
  assign lt_u  = src_a < src_b;
  assign eq    = src_a == src_b;
  assign shamt = src_b[SHW-1:0];

  // Branch ops return 0 when taken so zero doubles as the branch condition.
  always_comb begin
    base_res = '0;
    case (op)
      OP_ADD:    base_res = src_a + src_b;
      OP_SUB:    base_res = src_a - src_b;
      OP_AND:    base_res = src_a & src_b;
      OP_OR:     base_res = src_a | src_b;
      OP_XOR:    base_res = src_a ^ src_b;
      OP_SLL:    base_res = src_a << shamt;
      OP_SRL:    base_res = src_a >> shamt;
      OP_SRA:    base_res = $unsigned($signed(src_a) >>> shamt);
      OP_SLT:    base_res = XLEN'(lt_s);
      OP_LUI:    base_res = src_b;
      OP_SLTU:   base_res = XLEN'(lt_u);
      OP_BGE:    base_res = XLEN'(lt_s);
      OP_BGEU:   base_res = XLEN'(lt_u);
      OP_ADDPC:  base_res = src_a + XLEN'(4);
      OP_JBADDR: base_res = src_a - XLEN'(4) + src_b;
      OP_BNE:    base_res = XLEN'(eq);
      OP_BLT:    base_res = XLEN'(!lt_s);
      OP_BLTU:   base_res = XLEN'(!lt_u);
      default:   base_res = '0;
    endcase
  end

  // Multiply unsigned magnitudes and negate the product once at the end.
  assign mul_sa = ((op == OP_MULH) || (op == OP_MULHSU)) && src_a[XLEN-1];
  assign mul_sb = (op == OP_MULH) && src_b[XLEN-1];
  assign a_mag  = mul_sa ? -src_a : src_a;
  assign b_mag  = mul_sb ? -src_b : src_b;

  always_comb begin
    acc_step = acc_q;
    for (int j = 0; j < MUL_UNROLL; j++) begin
      if (mplier_q[j]) acc_step = acc_step + (mcand_q << j);
    end
  end

  assign prod = mneg_q ? -acc_step : acc_step;

  riscv_alu_divider #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .start     (div_start),
    .is_signed ((op == OP_DIV) || (op == OP_REM)),
    .dividend  (src_a),
    .divisor   (src_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    result_d  = result_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    mcnt_d    = mcnt_q;
    mneg_d    = mneg_q;
    div_start = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        op_d = op;
        if (is_mul_op(op)) begin
          state_d  = MUL;
          acc_d    = '0;
          mcand_d  = {{XLEN{1'b0}}, a_mag};
          mplier_d = b_mag;
          mcnt_d   = '0;
          mneg_d   = mul_sa ^ mul_sb;
        end else if (is_mop(op)) begin
          state_d   = DIV;
          div_start = 1'b1;
        end else begin
          state_d  = DONE;
          result_d = base_res;
        end
      end
      MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << MUL_UNROLL;
        mplier_d = mplier_q >> MUL_UNROLL;
        mcnt_d   = mcnt_q + CW'(1);
        if (mcnt_q == CW'(MUL_CYC - 1)) begin
          state_d  = DONE;
          result_d = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
      end
      DIV: if (div_done) begin
        state_d  = DONE;
        result_d = is_rem_op(op_q) ? div_rem : div_quo;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q     <= op_d;
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    mcnt_q   <= mcnt_d;
    mneg_q   <= mneg_d;
  end

endmodule

// File: tb/tb_riscv_alu_mc.sv
// Scoreboard bench for riscv_alu_mc: the driver queues hand-computed results,
// a negedge monitor checks result, zero, latency and in_ready.
module tb_riscv_alu_mc;
  import riscv_alu_pkg::*;

  localparam int XLEN = 32;
  localparam int MU   = 1;

  logic            clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, zero;
  logic [4:0]      op;
  logic [XLEN-1:0] src_a, src_b, result;

  riscv_alu_mc #(.XLEN(XLEN), .MUL_UNROLL(MU), .OPW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] res;
    int              lat;
    int              acc_cyc;
    string           nm;
  } exp_t;

  exp_t sb_q[$];
  exp_t head;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   seen  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_lat(input logic [4:0] o);
    if (o >= 5'd19 && o <= 5'd22) return XLEN / MU + 1;
    if (o >= 5'd23 && o <= 5'd26) return XLEN + 1;
    return 1;
  endfunction

  // Monitor: compares the queue head every cycle the result is presented.
  always @(negedge clk) begin
    if (rst_n && !flush) begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check("spurious_out_valid", out_valid, 1'b0);
        end else begin
          head = sb_q[0];
          if (!seen) begin
            check({head.nm, "_latency"}, cyc - head.acc_cyc + 1, head.lat);
            seen = 1'b1;
          end
          check(head.nm, result, head.res);
          check({head.nm, "_zero"}, zero, head.res == '0);
          check({head.nm, "_in_ready_done"}, in_ready, 1'b0);
          if (out_ready) begin
            void'(sb_q.pop_front());
            seen = 1'b0;
          end
        end
      end else if (sb_q.size() != 0) begin
        check({sb_q[0].nm, "_in_ready_busy"}, in_ready, 1'b0);
      end
    end
  end

  // Called just after a posedge; holds in_valid until the unit accepts.
  task automatic issue(input logic [4:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] e, input string nm);
    exp_t it;
    int   w = 0;
    op = o; src_a = a; src_b = b; in_valid = 1'b1;
    while (!in_ready && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      check({nm, "_accept_timeout"}, in_ready, 1'b1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid   = 1'b0;
      it.res     = e;
      it.lat     = exp_lat(o);
      it.acc_cyc = cyc;
      it.nm      = nm;
      sb_q.push_back(it);
    end
  endtask

  task automatic drain();
    int w = 0;
    while (sb_q.size() != 0 && w < 500) begin
      @(posedge clk);
      w++;
    end
    if (sb_q.size() != 0) check("drain_timeout", sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input string nm);
    check({nm, "_in_ready"}, in_ready, 1'b1);
    check({nm, "_out_valid"}, out_valid, 1'b0);
    check({nm, "_result"}, result, '0);
    check({nm, "_zero"}, zero, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Base ops, back to back.
    issue(OP_ADD,    32'd7,          32'hFFFF_FFF9, 32'h0000_0000, "add_zero");
    issue(OP_SUB,    32'd10,         32'd3,         32'd7,         "sub");
    issue(OP_AND,    32'hF0F0_1234,  32'h0FF0_FF00, 32'h00F0_1200, "and");
    issue(OP_OR,     32'hF000_000F,  32'h0000_0F00, 32'hF000_0F0F, "or");
    issue(OP_XOR,    32'hFFFF_0000,  32'h0F0F_0F0F, 32'hF0F0_0F0F, "xor");
    issue(OP_SLL,    32'd1,          32'h0000_0021, 32'd2,         "sll_mask");
    issue(OP_SRL,    32'h8000_0000,  32'd4,         32'h0800_0000, "srl");
    issue(OP_SRA,    32'h8000_0000,  32'd4,         32'hF800_0000, "sra");
    issue(OP_SLT,    32'hFFFF_FFFF,  32'd1,         32'd1,         "slt");
    issue(OP_SLTU,   32'hFFFF_FFFF,  32'd1,         32'd0,         "sltu");
    issue(OP_LUI,    32'hDEAD_BEEF,  32'h1234_5000, 32'h1234_5000, "lui");
    issue(OP_BGE,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0,         "bge_taken");
    issue(OP_BGEU,   32'd1,          32'hFFFF_FFFF, 32'd1,         "bgeu_not");
    issue(OP_ADDPC,  32'h0000_0100,  32'd0,         32'h0000_0104, "addpc");
    issue(OP_JBADDR, 32'h0000_0100,  32'h0000_0020, 32'h0000_011C, "jbaddr");
    issue(OP_BNE,    32'd5,          32'd5,         32'd1,         "bne_not");
    issue(OP_BLT,    32'hFFFF_FFFB,  32'd3,         32'd0,         "blt_taken");
    issue(OP_BLTU,   32'd3,          32'hFFFF_FFFB, 32'd0,         "bltu_taken");
    issue(5'd0,      32'd9,          32'd9,         32'd0,         "undef_0");
    issue(5'd31,     32'd9,          32'd9,         32'd0,         "undef_31");

    // Multiply.
    issue(OP_MUL,    32'd6,          32'd7,         32'd42,        "mul");
    issue(OP_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         "mul_m1");
    issue(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
    issue(OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0,         "mulh_m1");
    issue(OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "mulh_min");
    issue(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");

    // Divide, including the overflow and divide-by-zero corners.
    issue(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    issue(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         "rem_ovf");
    issue(OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, "divu_dz");
    issue(OP_REMU,   32'd5,          32'd0,         32'd5,         "remu_dz");
    issue(OP_DIV,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, "div_dz_neg");
    issue(OP_REM,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, "rem_dz_neg");
    issue(OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "div_m7_2");
    issue(OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "rem_m7_2");
    issue(OP_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2");
    issue(OP_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         "rem_7_m2");
    issue(OP_DIVU,   32'd100,        32'd7,         32'd14,        "divu");
    issue(OP_REMU,   32'd100,        32'd7,         32'd2,         "remu");
    drain();

    // Hold the result for 5 cycles while the next op waits at the input.
    out_ready = 1'b0;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "hold_div");
    fork
      issue(OP_ADD, 32'd1, 32'd2, 32'd3, "after_hold");
      begin : release_proc
        int w = 0;
        while (!out_valid && w < 100) begin
          @(posedge clk); #1;
          w++;
        end
        if (!out_valid) check("hold_wait_timeout", out_valid, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Flush in the middle of a divide.
    op = OP_DIV; src_a = 32'd100; src_b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("flush_pre_in_ready", in_ready, 1'b0);
    check("flush_pre_result", result, 32'd3);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_idle("flush_mid_div");
    repeat (40) @(posedge clk);
    #1;
    issue(OP_ADD, 32'd5, 32'd6, 32'd11, "post_flush_add");
    drain();

    // Reset in the middle of a divide.
    op = OP_DIVU; src_a = 32'd50; src_b = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_idle("rst_mid_div");
    repeat (40) @(posedge clk);
    #1;

    // flush and in_valid together: flush wins, nothing accepted.
    op = OP_ADD; src_a = 32'd1; src_b = 32'd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_vs_valid_out_valid", out_valid, 1'b0);
    check("flush_vs_valid_in_ready", in_ready, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "final_mulhu");
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
